// File: rtl/nabp_image_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_image_writer_if : NABP pixel stream, image RAM write port and status   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface nabp_image_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
);
  logic              nb_kick;
  logic              nb_done;
  logic [ADDR_W-1:0] nb_addr;
  logic [DATA_W-1:0] nb_val;
  logic              nb_enable;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_ready;
  logic              frame_done;
  logic [ADDR_W:0]   pixel_count;
  logic              addr_err;

  modport slave (
    input  nb_kick, nb_done, nb_addr, nb_val, mem_ready,
    output nb_enable, mem_wr_en, mem_wr_addr, mem_wr_data,
           frame_done, pixel_count, addr_err
  );

  modport master (
    output nb_kick, nb_done, nb_addr, nb_val, mem_ready,
    input  nb_enable, mem_wr_en, mem_wr_addr, mem_wr_data,
           frame_done, pixel_count, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/nabp_image_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_image_writer : buffers the NABP pixel stream and writes it to image RAM|
// | Optional address checker: NABP_IMAGE_WRITER_CHECK_EN.  Rev 1.0              |
// +----------------------------------------------------------------------------+
module nabp_image_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  nabp_image_writer_if.slave bus
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ent_w = ADDR_W + DATA_W;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [c_ent_w-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;

  logic               slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0]  slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]  slot_data_q, slot_data_d;
  logic [ADDR_W:0]    pix_cnt_q, pix_cnt_d;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_enable;
  logic               w_beat;
  logic               w_pop;
  logic               w_wr_done;
  logic               w_start;
  logic               w_frame_done;
  logic [c_ent_w-1:0] w_head;

  assign w_fifo_full  = (count_q == c_depth);
  assign w_fifo_empty = (count_q == '0);
  assign w_wr_done    = slot_valid_q & bus.mem_ready;
  assign w_beat       = w_enable;
  // The slot refills in the same cycle its write completes, so a ready RAM sees no bubble.
  assign w_pop        = !w_fifo_empty && (!slot_valid_q || w_wr_done);
  assign w_head       = fifo_mem_q[rd_ptr_q];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    w_enable     = 1'b0;
    w_frame_done = 1'b0;
    w_start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.nb_kick) begin
          state_d = S_STREAM;
          w_start = 1'b1;
        end
      end
      S_STREAM: begin
        w_enable = !w_fifo_full;
        if (bus.nb_done) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the final write completes so frame_done follows it by one cycle.
        if (w_fifo_empty && (!slot_valid_q || w_wr_done)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    pix_cnt_d    = pix_cnt_q;

    if (w_beat) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_beat, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (w_pop) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = w_head[c_ent_w-1:DATA_W];
      slot_data_d  = w_head[DATA_W-1:0];
    end else if (w_wr_done) begin
      slot_valid_d = 1'b0;
    end

    if (w_start) begin
      pix_cnt_d = '0;
    end else if (w_wr_done && (pix_cnt_q != '1)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      pix_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      fifo_mem_q[wr_ptr_q] <= {bus.nb_addr, bus.nb_val};
    end
  end

  // ---------------------------------------------------------------- address checker
`ifdef NABP_IMAGE_WRITER_CHECK_EN
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              addr_err_q, addr_err_d;

  always_comb begin
    exp_addr_d = exp_addr_q;
    addr_err_d = addr_err_q;
    if (w_start) begin
      exp_addr_d = '0;
      addr_err_d = 1'b0;
    end else if (w_beat) begin
      exp_addr_d = exp_addr_q + 1'b1;
      if (bus.nb_addr != exp_addr_q) begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.addr_err = addr_err_q;
`else
  assign bus.addr_err = 1'b0;
`endif

  assign bus.nb_enable   = w_enable;
  assign bus.mem_wr_en   = slot_valid_q;
  assign bus.mem_wr_addr = slot_addr_q;
  assign bus.mem_wr_data = slot_data_q;
  assign bus.frame_done  = w_frame_done;
  assign bus.pixel_count = pix_cnt_q;

endmodule
`default_nettype wire

// File: doc/nabp_image_writer.md
# nabp_image_writer

Downstream stage of the NABP core: accepts the reconstructed pixel stream emitted by the processing-element domino chain and writes it into image RAM. Decouples the PE chain from RAM stalls with a small FIFO and throttles the chain through the enable handshake. Reports per-frame completion and the written-pixel count to the host.

## Interface
Parameters:
- DATA_W, 16, pixel value width (cache data length)
- ADDR_W, 14, image RAM address width
- FIFO_DEPTH, 8, buffer entries; power of two, at least 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- nb_kick  in  1  frame start pulse from NABP (ir_kick)
- nb_done  in  1  frame end from NABP (ir_done)
- nb_addr  in  ADDR_W  pixel address from NABP (ir_addr)
- nb_val  in  DATA_W  pixel value from NABP (ir_val)
- nb_enable  out  1  drives NABP ir_enable; a pixel beat is taken on each cycle this is high
- mem_wr_en  out  1  write request to image RAM
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- mem_ready  in  1  RAM accepts the write this cycle
- frame_done  out  1  one-cycle pulse when the frame has been fully written
- pixel_count  out  ADDR_W+1  number of RAM writes completed in the current or last frame
- addr_err  out  1  sticky sequence error (CHECK_EN builds only; tied 0 otherwise)

## Operation
- Write handshake: a write completes on any cycle where mem_wr_en=1 and mem_ready=1.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - nb_enable=0.
  - On nb_kick=1: go to STREAM, clear pixel_count, clear addr_err.
- STREAM:
  - nb_enable = !fifo_full, computed from the current occupancy.
  - Each beat pushes {nb_addr, nb_val} into the FIFO.
  - On nb_done=1: go to DRAIN. If a beat occurs in the same cycle, that beat is still pushed.
- DRAIN:
  - nb_enable=0.
  - When the FIFO is empty and the output register holds no pending write: go to DONE.
- DONE:
  - frame_done=1 for exactly this cycle, then go to IDLE.
- nb_kick outside IDLE is ignored.
- nb_done outside STREAM is ignored.
- Output stage:
  - A registered output slot holds the FIFO head.
  - mem_wr_en stays high while the slot is valid.
  - mem_wr_addr and mem_wr_data hold stable until the write completes.
  - After a completed write, the next entry loads the same cycle if one is available, with no bubble.
- pixel_count:
  - Increments on each completed write.
  - Saturates at 2^(ADDR_W+1)-1.
  - Holds its value after DONE until the next nb_kick.
- FIFO boundary rules:
  - Full: no push. A pop in the same cycle does not re-enable the push; nb_enable reopens the next cycle.
  - Empty: no pop.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: nb_enable=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, frame_done=0, pixel_count=0, addr_err=0. State=IDLE, FIFO empty.
- nb_kick at cycle t: nb_enable may be high at t+1.
- Latency: a beat at cycle t gives mem_wr_en=1 with that data at t+2 at the earliest (FIFO write, then output register).
- Sustained throughput is 1 pixel/cycle while mem_ready=1.
- With mem_ready held 0 from the start of STREAM, nb_enable drops after FIFO_DEPTH+1 beats (FIFO plus output slot).
- frame_done asserts one cycle after the last write completes.
- Reset asserted mid-frame:
  - Immediate asynchronous clear; buffered data is discarded.
  - No further writes are issued.
  - frame_done does not pulse.

## Configuration
- NABP_IMAGE_WRITER_CHECK_EN defined:
  - In STREAM, the block compares each beat's nb_addr with an expected address.
  - The expected address is 0 at nb_kick and increments modulo 2^ADDR_W per beat.
  - A mismatch sets addr_err, which stays high until the next nb_kick or reset.
  - The mismatching data is still written.
- Macro undefined: no checker logic is built and addr_err is tied 0.

## Test plan
- Basic frame: mem_ready=1, nb_kick, 4 beats with addr 0..3 and val 0x10..0x13, then nb_done -> 4 writes in order, pixel_count=4, single frame_done pulse, addr_err=0.
- Backpressure: mem_ready=0 after kick, continuous beats -> nb_enable falls after 9 beats with FIFO_DEPTH=8; mem_wr_addr/mem_wr_data stable. Release mem_ready -> 9 writes with no bubble.
- Done with a full FIFO: nb_done while 8 entries are buffered and mem_ready toggles 1/0 -> all entries written, then frame_done; nb_enable stays 0 throughout DRAIN.
- Kick while busy: second nb_kick during STREAM -> ignored, pixel_count not cleared, frame completes normally.
- Sequence error (CHECK_EN): addresses 0,1,3,4 -> addr_err rises on the beat carrying 3 and stays high; all 4 pixels are written. The next nb_kick clears it.
- Reset mid-frame: reset_n low after 3 beats with mem_ready=0 -> all outputs return to reset values at once. A fresh kick and 2-pixel frame then writes exactly 2 pixels.
